// File: rtl/blur_pkg.sv
// Shared definitions for the horizontal 3-tap blur: stream word layout,
// pixel structs and the window state encoding.
package blur_pkg;

  localparam int SOP_BIT = 25;
  localparam int EOP_BIT = 24;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;
  localparam int CH_W    = 8;
  localparam int NUM_CH  = 3;
  localparam int PIX_W   = SOP_BIT + 1;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Field order matches the stream word: SOP, EOP, R, G, B.
  typedef struct packed {
    logic sop;
    logic eop;
    rgb_t rgb;
  } pix_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } blur_state_t;

endpackage

// File: rtl/blur_h3_kernel.sv
// One colour channel of the [1 2 1]/4 kernel. Define STREAM_BLUR_H3_ROUND_EN
// for round-half-up; otherwise the result is truncated.
module blur_h3_kernel
  import blur_pkg::*;
(
  input  logic [CH_W-1:0] l,
  input  logic [CH_W-1:0] c,
  input  logic [CH_W-1:0] r,
  output logic [CH_W-1:0] y
);

`ifdef STREAM_BLUR_H3_ROUND_EN
  localparam logic [CH_W+1:0] BIAS = (CH_W+2)'(2);
`else
  localparam logic [CH_W+1:0] BIAS = '0;
`endif

  // Worst case 4*255 + 2 = 1022 still fits in ten bits.
  logic [CH_W+1:0] sum;

  assign sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + BIAS;
  assign y   = sum[CH_W+1:2];

endmodule

// File: rtl/stream_blur_h3.sv
// Horizontal [1 2 1]/4 blur over an RGB pixel stream with SOP/EOP framing and
// edge replication. Rounding selected by STREAM_BLUR_H3_ROUND_EN.
module stream_blur_h3
  import blur_pkg::*;
#(
  parameter int DATA_WIDTH = 26,
  parameter int IMG_WIDTH  = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready_in,
  output logic                  frame_err
);

  localparam int              COL_W    = $clog2(IMG_WIDTH + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  blur_state_t           state_reg, state_next;
  rgb_t                  left_reg, left_next;
  pix_t                  cen_reg, cen_next;
  logic [COL_W-1:0]      col_reg, col_next;
  logic                  valid_out_reg, valid_out_next;
  logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
  logic                  frame_err_reg, frame_err_next;

  pix_t pix_in;
  rgb_t right_rgb;
  rgb_t blur_rgb;
  logic out_free;
  logic accept;

  assign pix_in    = pix_t'(data_in[PIX_W-1:0]);
  assign out_free  = ~valid_out_reg | ready_in;
  assign ready_out = (state_reg != ST_FLUSH) & out_free;
  assign accept    = valid_in & ready_out;

  // While flushing, the centre pixel stands in for the missing right neighbour.
  assign right_rgb = (state_reg == ST_FLUSH) ? cen_reg.rgb : pix_in.rgb;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      blur_h3_kernel u_kernel (
        .l (left_reg[gi*CH_W +: CH_W]),
        .c (cen_reg.rgb[gi*CH_W +: CH_W]),
        .r (right_rgb[gi*CH_W +: CH_W]),
        .y (blur_rgb[gi*CH_W +: CH_W])
      );
    end
  endgenerate

  always_comb begin
    logic start_line;
    logic emit;

    state_next     = state_reg;
    left_next      = left_reg;
    cen_next       = cen_reg;
    col_next       = col_reg;
    valid_out_next = valid_out_reg & ~ready_in;
    data_out_next  = data_out_reg;
    frame_err_next = 1'b0;
    start_line     = 1'b0;
    emit           = 1'b0;

    unique case (state_reg)
      ST_FILL: begin
        start_line = accept;
      end
      ST_RUN: begin
        if (accept) begin
          if (pix_in.sop) begin
            // Restart on a stray SOP: the unfinished centre is abandoned.
            frame_err_next = 1'b1;
            start_line     = 1'b1;
          end else begin
            emit       = 1'b1;
            left_next  = cen_reg.rgb;
            cen_next   = pix_in;
            col_next   = col_reg + 1'b1;
            if (col_reg == LAST_COL || pix_in.eop) begin
              state_next = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          emit       = 1'b1;
          col_next   = '0;
          state_next = ST_FILL;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase

    if (start_line) begin
      left_next  = pix_in.rgb;
      cen_next   = pix_in;
      col_next   = COL_W'(1);
      state_next = pix_in.eop ? ST_FLUSH : ST_RUN;
    end

    if (emit) begin
      valid_out_next = 1'b1;
      data_out_next  = DATA_WIDTH'({cen_reg.sop, cen_reg.eop, blur_rgb});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      left_reg      <= '0;
      cen_reg       <= '0;
      col_reg       <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      left_reg      <= left_next;
      cen_reg       <= cen_next;
      col_reg       <= col_next;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_stream_blur_h3.sv
// Directed scoreboard bench for stream_blur_h3 with 4-pixel lines.
module tb_stream_blur_h3;

  localparam int DW = 26;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          ready_in;
  logic          frame_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [23:0]   line_px[W];
  bit            toggle_en = 0;
  bit            rand_idle = 0;
  int            out_cnt   = 0;
  int            ferr_cnt  = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] data_prev;

  stream_blur_h3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] blur1(input logic [7:0] l, input logic [7:0] c, input logic [7:0] r);
    int s;
    s = int'(l) + 2 * int'(c) + int'(r);
`ifdef STREAM_BLUR_H3_ROUND_EN
    s = s + 2;
`endif
    return 8'(s / 4);
  endfunction

  function automatic logic [23:0] blur_px(input logic [23:0] l, input logic [23:0] c, input logic [23:0] r);
    logic [23:0] res;
    for (int ch = 0; ch < 3; ch++)
      res[ch*8 +: 8] = blur1(l[ch*8 +: 8], c[ch*8 +: 8], r[ch*8 +: 8]);
    return res;
  endfunction

  // Reference for a full line: edge pixels replicated, flags on first/last.
  task automatic push_line(input int n);
    logic [23:0] l, c, r;
    for (int i = 0; i < n; i++) begin
      l = line_px[(i == 0) ? 0 : i - 1];
      c = line_px[i];
      r = line_px[(i == n - 1) ? n - 1 : i + 1];
      exp_q.push_back({i == 0, i == n - 1, blur_px(l, c, r)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle_en) ready_in = ~ready_in;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bit done;
    done     = 0;
    valid_in = 1'b1;
    data_in  = w;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = ready_out;
      step();
    end
    valid_in = 1'b0;
    check("accept", 32'(done), 32'd1);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_idle) repeat ($urandom_range(0, 2)) step();
      send_word({i == 0, i == n - 1, line_px[i]});
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard pops and hold-while-stalled checks.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(valid_out), 32'd1);
        check("hold_data", 32'(data_out), 32'(data_prev));
      end
      if (valid_out && ready_in) begin
        out_cnt++;
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (frame_err) ferr_cnt++;
      stall_prev = valid_out && !ready_in;
      data_prev  = data_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] p0, p1;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready_out", 32'(ready_out), 32'd1);

    // Flat grey line: one flush bubble after EOP.
    for (int i = 0; i < W; i++) line_px[i] = 24'h808080;
    push_line(W);
    send_line(W);
    @(negedge clk);
    check("flush_ready_low", 32'(ready_out), 32'd0);
    step();
    @(negedge clk);
    check("after_flush_ready", 32'(ready_out), 32'd1);
    drain("drain_flat");
    $display("txn flat line done outputs=%0d", out_cnt);

    // Red impulse.
    line_px[0] = 24'h0; line_px[1] = 24'h0; line_px[2] = 24'hFF0000; line_px[3] = 24'h0;
`ifdef STREAM_BLUR_H3_ROUND_EN
    exp_q.push_back({2'b10, 8'd0,   16'h0});
    exp_q.push_back({2'b00, 8'd64,  16'h0});
    exp_q.push_back({2'b00, 8'd128, 16'h0});
    exp_q.push_back({2'b01, 8'd64,  16'h0});
`else
    exp_q.push_back({2'b10, 8'd0,   16'h0});
    exp_q.push_back({2'b00, 8'd63,  16'h0});
    exp_q.push_back({2'b00, 8'd127, 16'h0});
    exp_q.push_back({2'b01, 8'd63,  16'h0});
`endif
    send_line(W);
    drain("drain_impulse");
    $display("txn impulse line done outputs=%0d", out_cnt);

    // Left edge replication.
    line_px[0] = 24'hFF0000; line_px[1] = 24'h0; line_px[2] = 24'h0; line_px[3] = 24'h0;
`ifdef STREAM_BLUR_H3_ROUND_EN
    exp_q.push_back({2'b10, 8'd191, 16'h0});
    exp_q.push_back({2'b00, 8'd64,  16'h0});
`else
    exp_q.push_back({2'b10, 8'd191, 16'h0});
    exp_q.push_back({2'b00, 8'd63,  16'h0});
`endif
    exp_q.push_back({2'b00, 24'h0});
    exp_q.push_back({2'b01, 24'h0});
    send_line(W);
    drain("drain_edge");
    $display("txn edge line done outputs=%0d", out_cnt);

    // Backpressure toggling with random input gaps.
    toggle_en = 1; rand_idle = 1;
    for (int ln = 0; ln < 3; ln++) begin
      for (int i = 0; i < W; i++) line_px[i] = 24'($urandom);
      push_line(W);
      send_line(W);
      $display("txn stalled line %0d sent", ln);
    end
    drain("drain_stall");
    toggle_en = 0; rand_idle = 0; ready_in = 1'b1;
    step();

    // Stray SOP at column 2.
    ferr_cnt = 0;
    p0 = 24'h10_20_30; p1 = 24'hF0_E0_D0;
    exp_q.push_back({2'b10, blur_px(p0, p0, p1)});
    send_word({2'b10, p0});
    send_word({2'b00, p1});
    line_px[0] = 24'h40_80_C0; line_px[1] = 24'hFF_00_7F;
    line_px[2] = 24'h01_02_03; line_px[3] = 24'hAA_55_AA;
    push_line(W);
    send_line(W);
    drain("drain_sop");
    check("frame_err_pulses", 32'(ferr_cnt), 32'd1);
    $display("txn stray sop done frame_err=%0d", ferr_cnt);

    // Reset mid-line with the first result held by backpressure.
    ready_in = 1'b0;
    send_word({2'b10, 24'h123456});
    send_word({2'b00, 24'h654321});
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'd0);
    ready_in = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < W; i++) line_px[i] = 24'h00_10_00 * 24'(i + 1);
    push_line(W);
    send_line(W);
    drain("drain_rst");
    repeat (3) step();
    check("rst_line_outputs", 32'(out_cnt), 32'd4);
    $display("txn post-reset line done outputs=%0d", out_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_blur_h3.md
# stream_blur_h3

Horizontal 3-tap [1 2 1]/4 blur on a 24-bit RGB pixel stream with SOP/EOP framing. Sits directly upstream of the blur-path stream register: consumes camera pixels over a valid/ready handshake and hands blurred pixels, framing flags unchanged, to that register. Line edges are handled by replicating the edge pixel. One bubble per line is spent flushing the last pixel.

## Interface
- `DATA_WIDTH`, 26: stream word width; bit 25 = SOP, bit 24 = EOP, 23:16 = R, 15:8 = G, 7:0 = B.
- `IMG_WIDTH`, 640: pixels per line, ≥ 2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `valid_in` in 1: upstream word valid.
- `data_in` in DATA_WIDTH: upstream word.
- `ready_out` out 1: block can accept `data_in` this cycle.
- `valid_out` out 1: `data_out` holds a blurred word.
- `data_out` out DATA_WIDTH: blurred word (registered).
- `ready_in` in 1: downstream accepts `data_out` this cycle.
- `frame_err` out 1: one-cycle pulse on framing violation.

## Operation
- Transfer in: `valid_in & ready_out`. Transfer out: `valid_out & ready_in`.
- Window registers: `left`, `cen` (pixel + SOP/EOP), column counter `col` (0..IMG_WIDTH-1).
- States: FILL (no centre held), RUN (centre held), FLUSH (emit last pixel of line, input stalled).
- FILL + accept p: `left=cen=p`, `col=1`, go RUN; no output. If p has EOP (1-pixel line): go FLUSH.
- RUN + accept p: emit blur(`left`,`cen`,p) with `cen` flags; `left=cen`, `cen=p`, `col++`. If `col` was IMG_WIDTH-1 or p has EOP: go FLUSH.
- FLUSH, when output register free: emit blur(`left`,`cen`,`cen`) with `cen` flags; `col=0`, go FILL.
- SOP accepted while in RUN: pending `cen` dropped, `frame_err` pulses, p treated as column 0 (FILL behaviour).
- EOP before column IMG_WIDTH-1: line flushed normally, `col` returns to 0, no error.
- Blur per channel: 10-bit sum `l + 2c + r`, result = sum[9:2]; max 1020 (1022 rounded) never overflows.

## Timing
- Reset values: `valid_out=0`, `data_out=0`, `frame_err=0`, state FILL, `col=0`.
- `ready_out = (state != FLUSH) & (~valid_out | ready_in)`; combinational, no dependence on `valid_in`.
- Output register loads on emit; while `valid_out & ~ready_in`, `data_out` is held stable and no emit occurs.
- Latency: output for column c valid cycle after column c+1 accepted; last pixel of line valid cycle after entering FLUSH with free output.
- Throughput: IMG_WIDTH outputs per IMG_WIDTH+1 cycles at full rate.
- Simultaneous emit and `ready_in`: old word leaves, new word loads same edge.
- `rst` mid-line: all state cleared next edge; partial line discarded, no output.

## Configuration
- `STREAM_BLUR_H3_ROUND_EN` defined: per-channel result = (sum + 2) >> 2 (round half up).
- Undefined: result = sum >> 2 (truncate). Nothing else changes.

## Structure
- Package `blur_pkg`: bit positions (SOP_BIT, EOP_BIT, channel offsets), `rgb_t` struct typedef, state enum `blur_state_t`.
- Sub-module `blur_h3_kernel`: combinational 8-bit l/c/r → 8-bit result for one channel, holds the rounding macro; instantiated three times.

## Test plan
- IMG_WIDTH=4, line of 0x808080 (SOP first, EOP last), `ready_in=1` → four outputs 0x808080, SOP on 1st, EOP on 4th, one `ready_out` low cycle.
- R impulse 0,0,255,0 → R out 0,63,127,63 truncated; 0,64,128,64 with ROUND_EN.
- Edge replicate: R 255,0,0,0 → first R output 191 (both modes).
- `ready_in` toggled 1/0 every cycle, random `valid_in` → output sequence identical to full-rate run, `data_out` stable while stalled.
- SOP at column 2 of 4 → `frame_err` pulses once, pending pixel dropped, new line outputs correct.
- `rst` asserted after 2 inputs → `valid_out=0` next cycle; following full line produces exactly 4 correct outputs.
